// File: rtl/fxp_dot_accum.sv
// Streaming saturating dot-product accumulator for Q2.14 products from mult.
// Sums a vector delimited by in_last and holds the result until the consumer takes it.
module fxp_dot_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 14,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_ovf,
  input  logic                  in_unf,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf,
  output logic                  out_unf,
  output logic                  out_sat
);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  localparam int EXT_WIDTH = ACC_WIDTH + 1;
  localparam int HI_WIDTH  = ACC_WIDTH - DATA_WIDTH + 1;

  state_t                 state_r;
  state_t                 state_nx_s;

  logic [ACC_WIDTH-1:0]   acc_r;
  logic [ACC_WIDTH-1:0]   acc_nx_s;
  logic [ACC_WIDTH-1:0]   acc_upd_s;
  logic [EXT_WIDTH-1:0]   term_ext_s;
  logic [EXT_WIDTH-1:0]   sum_s;
  logic                   acc_pos_clamp_s;
  logic                   acc_neg_clamp_s;

  logic [CNT_WIDTH-1:0]   count_r;
  logic [CNT_WIDTH-1:0]   count_nx_s;
  logic [CNT_WIDTH-1:0]   count_inc_s;

  logic                   ovf_r;
  logic                   ovf_nx_s;
  logic                   unf_r;
  logic                   unf_nx_s;

  logic                   load_out_s;
  logic [DATA_WIDTH:0]    conv_s;

  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic [ACC_WIDTH-1:0]   out_acc_r;
  logic [CNT_WIDTH-1:0]   out_count_r;
  logic                   out_ovf_r;
  logic                   out_unf_r;
  logic                   out_sat_r;

  // Narrow the accumulator back to Q2.14; result is {sat, data}.
  // The value fits when every bit from the data sign bit upward agrees.
  function automatic logic [DATA_WIDTH:0] to_q_sat(input logic [ACC_WIDTH-1:0] a);
    logic [HI_WIDTH-1:0]   hi;
    logic [DATA_WIDTH:0]   res;
    hi = a[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((hi == {HI_WIDTH{1'b0}}) || (hi == {HI_WIDTH{1'b1}})) begin
      res = {1'b0, a[DATA_WIDTH-1:FRAC_WIDTH], a[FRAC_WIDTH-1:0]};
    end else if (a[ACC_WIDTH-1]) begin
      res = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  // Saturating add of the incoming term and saturating term count.
  always_comb begin
    term_ext_s      = {{(EXT_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    sum_s           = {acc_r[ACC_WIDTH-1], acc_r} + term_ext_s;
    // One guard bit is enough: the top two bits disagree only on overflow.
    acc_pos_clamp_s = (sum_s[EXT_WIDTH-1:EXT_WIDTH-2] == 2'b01);
    acc_neg_clamp_s = (sum_s[EXT_WIDTH-1:EXT_WIDTH-2] == 2'b10);
    if (acc_pos_clamp_s) begin
      acc_upd_s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else if (acc_neg_clamp_s) begin
      acc_upd_s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      acc_upd_s = sum_s[ACC_WIDTH-1:0];
    end
    if (count_r == {CNT_WIDTH{1'b1}}) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and next-datapath decode for the ACCUM/OUTPUT controller.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    count_nx_s = count_r;
    ovf_nx_s   = ovf_r;
    unf_nx_s   = unf_r;
    load_out_s = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_nx_s   = acc_upd_s;
          count_nx_s = count_inc_s;
          ovf_nx_s   = ovf_r | in_ovf | acc_pos_clamp_s;
          unf_nx_s   = unf_r | in_unf | acc_neg_clamp_s;
          if (in_last) begin
            state_nx_s = ST_OUTPUT;
            load_out_s = 1'b1;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_nx_s = ST_ACCUM;
          acc_nx_s   = {ACC_WIDTH{1'b0}};
          count_nx_s = {CNT_WIDTH{1'b0}};
          ovf_nx_s   = 1'b0;
          unf_nx_s   = 1'b0;
        end else begin
          state_nx_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nx_s = ST_ACCUM;
        acc_nx_s   = {ACC_WIDTH{1'b0}};
        count_nx_s = {CNT_WIDTH{1'b0}};
        ovf_nx_s   = 1'b0;
        unf_nx_s   = 1'b0;
      end
    endcase
  end

  assign conv_s = to_q_sat(acc_nx_s);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Running accumulator, term counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r   <= {ACC_WIDTH{1'b0}};
      count_r <= {CNT_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nx_s;
      count_r <= count_nx_s;
      ovf_r   <= ovf_nx_s;
      unf_r   <= unf_nx_s;
    end
  end

  // Output registers; the result is captured together with the last term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_acc_r   <= {ACC_WIDTH{1'b0}};
      out_count_r <= {CNT_WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
      out_unf_r   <= 1'b0;
      out_sat_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == ST_ACCUM);
      out_valid_r <= (state_nx_s == ST_OUTPUT);
      if (load_out_s) begin
        out_data_r  <= conv_s[DATA_WIDTH-1:0];
        out_sat_r   <= conv_s[DATA_WIDTH];
        out_acc_r   <= acc_nx_s;
        out_count_r <= count_nx_s;
        out_ovf_r   <= ovf_nx_s;
        out_unf_r   <= unf_nx_s;
      end else begin
        out_data_r  <= out_data_r;
        out_sat_r   <= out_sat_r;
        out_acc_r   <= out_acc_r;
        out_count_r <= out_count_r;
        out_ovf_r   <= out_ovf_r;
        out_unf_r   <= out_unf_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_acc   = out_acc_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;
  assign out_unf   = out_unf_r;
  assign out_sat   = out_sat_r;

endmodule
